// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and the link constants common to uart_tx/uart_rx.
package uart_pkg;

    localparam int UART_DATA_BITS    = 8;
    localparam int UART_CLKS_PER_BIT = 16;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } rx_state_t;

    // Counter width that never collapses to zero bits for tiny ranges.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input; RESET_VAL sets the flop state held in reset.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic areset,
    input  logic d,
    output logic q
);

    logic sync_p0;
    logic sync_p1;

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            sync_p0 <= RESET_VAL;
            sync_p1 <= RESET_VAL;
        end else begin
            sync_p0 <= d;
            sync_p1 <= sync_p0;
        end
    end

    assign q = sync_p1;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling and one-cycle valid/frame_err/parity_err strobes.
// Define UART_RX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int DATA_BITS    = UART_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 areset,
    input  logic                 rx_serial,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 busy
);

    localparam int CNT_W = cnt_width(CLKS_PER_BIT);
    localparam int BIT_W = cnt_width(DATA_BITS);

    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

    rx_state_t            state;
    logic [CNT_W-1:0]     cnt;
    logic [BIT_W-1:0]     bit_idx;
    logic [DATA_BITS-1:0] shift;
    logic                 rx_s;

    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk    (clk),
        .areset (areset),
        .d      (rx_serial),
        .q      (rx_s)
    );

`ifdef UART_RX_PARITY_EN
    logic par_bit;
    logic parity_err_q;

    // Even parity: data bits plus parity bit must carry an even number of ones.
    function automatic logic parity_good(input logic [DATA_BITS-1:0] d, input logic p);
        return ~(^{d, p});
    endfunction

    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit      <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            valid     <= 1'b0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    cnt     <= '0;
                    bit_idx <= '0;
                    if (!rx_s) begin
                        state <= START;
                    end
                end

                // Re-check the line half a bit in so short low glitches are rejected.
                START: begin
                    if (cnt == CNT_HALF) begin
                        cnt   <= '0;
                        state <= rx_s ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                DATA: begin
                    if (cnt == CNT_LAST) begin
                        cnt   <= '0;
                        shift <= {rx_s, shift[DATA_BITS-1:1]};
                        if (bit_idx == BIT_LAST) begin
                            bit_idx <= '0;
`ifdef UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (cnt == CNT_LAST) begin
                        cnt     <= '0;
                        par_bit <= rx_s;
                        state   <= STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`endif

                // Leaving mid stop bit keeps the next start edge visible at full line rate.
                STOP: begin
                    if (cnt == CNT_LAST) begin
                        cnt <= '0;
                        if (!rx_s) begin
                            frame_err <= 1'b1;
                            state     <= BREAK;
                        end else begin
                            state <= IDLE;
`ifdef UART_RX_PARITY_EN
                            if (parity_good(shift, par_bit)) begin
                                data  <= shift;
                                valid <= 1'b1;
                            end else begin
                                parity_err_q <= 1'b1;
                            end
`else
                            data  <= shift;
                            valid <= 1'b1;
`endif
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                BREAK: begin
                    cnt <= '0;
                    if (rx_s) begin
                        state <= IDLE;
                    end
                end

                default: begin
                    cnt   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: drives serial frames and compares strobes against a frame-level model.
module tb_uart_rx;

    localparam int CPB = 16;
    localparam int DB  = 8;
`ifdef UART_RX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int FRAME_CYC = CPB * (DB + 2 + PB);
    localparam int LAT_EXP   = 2 + (CPB - 1) / 2 + (DB + 1 + PB) * CPB;

    logic          clk = 1'b0;
    logic          areset = 1'b1;
    logic          rx_serial = 1'b1;
    logic [DB-1:0] data;
    logic          valid;
    logic          frame_err;
    logic          parity_err;
    logic          busy;

    uart_rx #(
        .CLKS_PER_BIT (CPB),
        .DATA_BITS    (DB)
    ) dut (
        .clk        (clk),
        .areset     (areset),
        .rx_serial  (rx_serial),
        .data       (data),
        .valid      (valid),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [DB-1:0] vq[$];
    int            vcyc[$];
    int            fe_cnt = 0;
    int            pe_cnt = 0;
    int            both_cnt = 0;
    int            busy_cnt = 0;

    always @(negedge clk) begin
        if (valid === 1'b1) begin
            vq.push_back(data);
            vcyc.push_back(cyc);
        end
        if (frame_err === 1'b1) fe_cnt <= fe_cnt + 1;
        if (parity_err === 1'b1) pe_cnt <= pe_cnt + 1;
        if (valid === 1'b1 && (frame_err === 1'b1 || parity_err === 1'b1)) both_cnt <= both_cnt + 1;
        if (busy === 1'b1) busy_cnt <= busy_cnt + 1;
    end

    int            n_cmp = 0;
    int            n_fail = 0;
    logic [DB-1:0] model_data = '0;
    int            t_start = 0;

    // Frame-level reference: 0 = good byte, 1 = framing error, 2 = parity error.
    function automatic int outcome(input logic [DB-1:0] b, input logic stop, input logic par);
        if (!stop) return 1;
        if (PB == 1 && ((^b) != par)) return 2;
        return 0;
    endfunction

    // Called at a negedge; leaves the line at the stop-bit level.
    task automatic send_frame(input logic [DB-1:0] b, input logic stop, input logic par);
        rx_serial = 1'b0;
        t_start = cyc;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < DB; i++) begin
            rx_serial = b[i];
            repeat (CPB) @(negedge clk);
        end
        if (PB == 1) begin
            rx_serial = par;
            repeat (CPB) @(negedge clk);
        end
        rx_serial = stop;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        while (busy !== 1'b0 && k < budget) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic test_reset;
        areset = 1'b1;
        rx_serial = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if (data !== '0) begin n_fail++; $display("FAIL reset_data got %h want 00", data); end
        n_cmp++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", valid); end
        n_cmp++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err got %b want 0", frame_err); end
        n_cmp++; if (parity_err !== 1'b0) begin n_fail++; $display("FAIL reset_parity_err got %b want 0", parity_err); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        areset = 1'b0;
        repeat (20) @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL post_reset_busy got %b want 0", busy); end
        n_cmp++; if (vq.size() != 0 || fe_cnt != 0) begin
            n_fail++; $display("FAIL post_reset_strobes got valid=%0d ferr=%0d want 0/0", vq.size(), fe_cnt);
        end
    endtask

    task automatic test_single;
        int v0, f0, lat;
        v0 = vq.size(); f0 = fe_cnt;
        send_frame(8'hA5, 1'b1, ^8'hA5);
        wait_idle(40);
        repeat (2) @(negedge clk);
        n_cmp++; if (vq.size() - v0 != 1) begin n_fail++; $display("FAIL single_count got %0d want 1", vq.size() - v0); end
        if (vq.size() > v0) begin
            lat = vcyc[v0] - t_start;
            n_cmp++; if (vq[v0] !== 8'hA5) begin n_fail++; $display("FAIL single_strobe_data got %h want a5", vq[v0]); end
            n_cmp++; if (lat < LAT_EXP - 3 || lat > LAT_EXP + 3) begin
                n_fail++; $display("FAIL single_latency got %0d want %0d+-3", lat, LAT_EXP);
            end
        end
        n_cmp++; if (fe_cnt - f0 != 0) begin n_fail++; $display("FAIL single_frame_err got %0d want 0", fe_cnt - f0); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy got %b want 0", busy); end
        model_data = 8'hA5;
        n_cmp++; if (data !== model_data) begin n_fail++; $display("FAIL single_data got %h want %h", data, model_data); end
    endtask

    task automatic test_back_to_back;
        int v0;
        v0 = vq.size();
        send_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, ^8'hFF);
        wait_idle(40);
        repeat (2) @(negedge clk);
        n_cmp++; if (vq.size() - v0 != 2) begin n_fail++; $display("FAIL b2b_count got %0d want 2", vq.size() - v0); end
        if (vq.size() - v0 >= 2) begin
            n_cmp++; if (vq[v0] !== 8'h00) begin n_fail++; $display("FAIL b2b_first got %h want 00", vq[v0]); end
            n_cmp++; if (vq[v0+1] !== 8'hFF) begin n_fail++; $display("FAIL b2b_second got %h want ff", vq[v0+1]); end
            n_cmp++; if (vcyc[v0+1] - vcyc[v0] != FRAME_CYC) begin
                n_fail++; $display("FAIL b2b_spacing got %0d want %0d", vcyc[v0+1] - vcyc[v0], FRAME_CYC);
            end
        end
        model_data = 8'hFF;
    endtask

    task automatic test_glitch;
        int v0, f0, b0, bd;
        v0 = vq.size(); f0 = fe_cnt; b0 = busy_cnt;
        rx_serial = 1'b0;
        repeat (5) @(negedge clk);
        rx_serial = 1'b1;
        repeat (30) @(negedge clk);
        bd = busy_cnt - b0;
        n_cmp++; if (vq.size() != v0) begin n_fail++; $display("FAIL glitch_valid got %0d want 0", vq.size() - v0); end
        n_cmp++; if (fe_cnt != f0) begin n_fail++; $display("FAIL glitch_frame_err got %0d want 0", fe_cnt - f0); end
        n_cmp++; if (bd < 1 || bd > 10) begin n_fail++; $display("FAIL glitch_busy_cycles got %0d want 1..10", bd); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL glitch_idle got %b want 0", busy); end
    endtask

    task automatic test_break;
        int v0, f0;
        v0 = vq.size(); f0 = fe_cnt;
        send_frame(8'h3C, 1'b0, ^8'h3C);
        repeat (100) @(negedge clk);
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL break_held_busy got %b want 1", busy); end
        n_cmp++; if (fe_cnt - f0 != 1) begin n_fail++; $display("FAIL break_held_ferr got %0d want 1", fe_cnt - f0); end
        rx_serial = 1'b1;
        wait_idle(10);
        repeat (2) @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL break_release_busy got %b want 0", busy); end
        n_cmp++; if (fe_cnt - f0 != 1) begin n_fail++; $display("FAIL break_ferr_count got %0d want 1", fe_cnt - f0); end
        n_cmp++; if (vq.size() != v0) begin n_fail++; $display("FAIL break_valid got %0d want 0", vq.size() - v0); end
        n_cmp++; if (data !== model_data) begin n_fail++; $display("FAIL break_data got %h want %h", data, model_data); end
    endtask

    task automatic test_reset_mid_frame;
        int v0, f0;
        logic [DB-1:0] b;
        b = 8'h81;
        rx_serial = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            rx_serial = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx_serial = b[3];
        repeat (CPB / 2) @(negedge clk);
        areset = 1'b1;
        @(negedge clk);
        model_data = '0;
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got %b want 0", busy); end
        n_cmp++; if (data !== model_data) begin n_fail++; $display("FAIL abort_data got %h want 00", data); end
        repeat (2) @(negedge clk);
        rx_serial = 1'b1;
        areset = 1'b0;
        repeat (5) @(negedge clk);
        v0 = vq.size(); f0 = fe_cnt;
        send_frame(8'h42, 1'b1, ^8'h42);
        wait_idle(40);
        repeat (2) @(negedge clk);
        n_cmp++; if (vq.size() - v0 != 1) begin n_fail++; $display("FAIL abort_next_count got %0d want 1", vq.size() - v0); end
        if (vq.size() > v0) begin
            n_cmp++; if (vq[v0] !== 8'h42) begin n_fail++; $display("FAIL abort_next_data got %h want 42", vq[v0]); end
        end
        n_cmp++; if (fe_cnt != f0) begin n_fail++; $display("FAIL abort_next_ferr got %0d want 0", fe_cnt - f0); end
        model_data = 8'h42;
    endtask

    task automatic test_loopback;
        int v0;
        logic [DB-1:0] msg[2];
        msg[0] = 8'h48; msg[1] = 8'h69;
        v0 = vq.size();
        for (int i = 0; i < 2; i++) begin
            send_frame(msg[i], 1'b1, ^msg[i]);
            repeat ($urandom_range(0, 8)) @(negedge clk);
        end
        wait_idle(40);
        repeat (2) @(negedge clk);
        n_cmp++; if (vq.size() - v0 != 2) begin n_fail++; $display("FAIL loopback_count got %0d want 2", vq.size() - v0); end
        for (int i = 0; i < 2; i++) begin
            if (vq.size() > v0 + i) begin
                n_cmp++; if (vq[v0+i] !== msg[i]) begin
                    n_fail++; $display("FAIL loopback_byte%0d got %h want %h", i, vq[v0+i], msg[i]);
                end
            end
        end
        model_data = 8'h69;
    endtask

    task automatic test_random;
        int v0, f0, p0, exp_fe, exp_pe, oc;
        logic [DB-1:0] exp_q[$];
        logic [DB-1:0] b;
        logic stop, par;
        v0 = vq.size(); f0 = fe_cnt; p0 = pe_cnt;
        exp_fe = 0; exp_pe = 0;
        for (int n = 0; n < 24; n++) begin
            b = DB'($urandom_range(0, 255));
            stop = ($urandom_range(0, 5) != 0);
            par = (^b) ^ ($urandom_range(0, 4) == 0);
            oc = outcome(b, stop, par);
            if (oc == 0) begin exp_q.push_back(b); model_data = b; end
            else if (oc == 1) exp_fe++;
            else exp_pe++;
            send_frame(b, stop, par);
            if (!stop) begin
                rx_serial = 1'b1;
                repeat (4) @(negedge clk);
            end
            repeat ($urandom_range(0, 12)) @(negedge clk);
        end
        wait_idle(40);
        repeat (2) @(negedge clk);
        n_cmp++; if (vq.size() - v0 != exp_q.size()) begin
            n_fail++; $display("FAIL rand_count got %0d want %0d", vq.size() - v0, exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            if (vq.size() > v0 + i) begin
                n_cmp++; if (vq[v0+i] !== exp_q[i]) begin
                    n_fail++; $display("FAIL rand_byte%0d got %h want %h", i, vq[v0+i], exp_q[i]);
                end
            end
        end
        n_cmp++; if (fe_cnt - f0 != exp_fe) begin n_fail++; $display("FAIL rand_ferr got %0d want %0d", fe_cnt - f0, exp_fe); end
        n_cmp++; if (pe_cnt - p0 != exp_pe) begin n_fail++; $display("FAIL rand_perr got %0d want %0d", pe_cnt - p0, exp_pe); end
        n_cmp++; if (data !== model_data) begin n_fail++; $display("FAIL rand_data got %h want %h", data, model_data); end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity;
        int v0, f0, p0;
        v0 = vq.size(); f0 = fe_cnt; p0 = pe_cnt;
        send_frame(8'h07, 1'b1, 1'b0);
        repeat (10) @(negedge clk);
        n_cmp++; if (pe_cnt - p0 != 1) begin n_fail++; $display("FAIL parity_bad_perr got %0d want 1", pe_cnt - p0); end
        n_cmp++; if (vq.size() != v0) begin n_fail++; $display("FAIL parity_bad_valid got %0d want 0", vq.size() - v0); end
        n_cmp++; if (data !== model_data) begin n_fail++; $display("FAIL parity_bad_data got %h want %h", data, model_data); end
        send_frame(8'h07, 1'b1, 1'b1);
        repeat (10) @(negedge clk);
        n_cmp++; if (vq.size() - v0 != 1) begin n_fail++; $display("FAIL parity_good_count got %0d want 1", vq.size() - v0); end
        n_cmp++; if (data !== 8'h07) begin n_fail++; $display("FAIL parity_good_data got %h want 07", data); end
        model_data = 8'h07;
        p0 = pe_cnt;
        send_frame(8'h07, 1'b0, 1'b0);
        rx_serial = 1'b1;
        repeat (10) @(negedge clk);
        n_cmp++; if (fe_cnt - f0 != 1 || pe_cnt != p0) begin
            n_fail++; $display("FAIL parity_priority got ferr=%0d perr=%0d want 1/0", fe_cnt - f0, pe_cnt - p0);
        end
    endtask
`endif

    initial begin
        test_reset();
        @(negedge clk);
        test_single();
        test_back_to_back();
        test_glitch();
        test_break();
        test_reset_mid_frame();
        test_loopback();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        test_random();
        n_cmp++; if (both_cnt != 0) begin n_fail++; $display("FAIL exclusive_strobes got %0d want 0", both_cnt); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #(60000 * 10);
        $display("FAIL watchdog got timeout at cycle %0d want completion", cyc);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
        $fatal(1);
    end

endmodule
